// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Package : axi_lite_pkg
// Brief   : AXI4-Lite response codes, channel FSM state types, lane helpers.
// Rev     : 1.0
// ============================================================================
package axi_lite_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_EXEC = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ACC  = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  function automatic logic [31:0] byte_swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [3:0] strb_swap(input logic [3:0] s);
    return {s[0], s[1], s[2], s[3]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_ram_if.sv
`default_nettype none
// ============================================================================
// Interface : axi_lite_ram_if
// Brief     : AXI4-Lite bus bundle (AR/R/AW/W/B) with master/slave modports.
// Rev       : 1.0
// ============================================================================
interface axi_lite_ram_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface
`default_nettype wire

// File: rtl/ram_sp_be.sv
`default_nettype none
// ============================================================================
// Module : ram_sp_be
// Brief  : Single-port 32-bit word RAM, synchronous read, 4 byte enables.
// Rev    : 1.0
// ============================================================================
module ram_sp_be #(
  parameter int DEPTH_WORDS = 4096
) (
  input  wire logic                           clk,
  input  wire logic                           en,
  input  wire logic [3:0]                     we,
  input  wire logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  wire logic [31:0]                    wdata,
  output      logic [31:0]                    rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Read-first: rdata shows the word as it was before any same-cycle write.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) r_mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      rdata <= r_mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_lite_ram.sv
`default_nettype none
// ============================================================================
// Module : axi_lite_ram
// Brief  : AXI4-Lite responder over a single-port word RAM; independent read
//          and write FSMs, write wins the port. Option: AXI_RAM_BIG_ENDIAN_EN.
// Rev    : 1.0
// ============================================================================
module axi_lite_ram
  import axi_lite_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  wire logic         clk,
  input  wire logic         rstn,
  axi_lite_ram_if.slave     s_axi
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

  function automatic logic addr_ok(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return !off[32] && (off < SPAN);
  endfunction

  function automatic logic [AW-1:0] addr_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return AW'(off >> 2);
  endfunction

  wr_state_t   r_wst, w_wst_nxt;
  rd_state_t   r_rst, w_rst_nxt;
  logic        r_aw_held, r_w_held, w_aw_held_nxt, w_w_held_nxt;
  logic        r_aw_ok, r_ar_ok;
  logic [AW-1:0] r_aw_idx, r_ar_idx;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic        w_awready_nxt, w_wready_nxt, w_bvalid_nxt, w_arready_nxt, w_rvalid_nxt;
  logic [1:0]  r_bresp, w_bresp_nxt, r_rresp;
  logic [31:0] r_rdata;
  logic        w_aw_hs, w_w_hs, w_ar_hs;
  logic        w_ram_wr, w_ram_rd, w_ram_en;
  logic [AW-1:0] w_ram_addr;
  logic [3:0]  w_ram_we;
  logic [31:0] w_ram_wdata, w_ram_rdata, w_rd_word;

  assign w_aw_hs = s_axi.awvalid && r_awready;
  assign w_w_hs  = s_axi.wvalid && r_wready;
  assign w_ar_hs = s_axi.arvalid && r_arready;

  always_comb begin
    w_wst_nxt     = r_wst;
    w_aw_held_nxt = r_aw_held;
    w_w_held_nxt  = r_w_held;
    w_bresp_nxt   = r_bresp;
    case (r_wst)
      W_IDLE: begin
        w_aw_held_nxt = r_aw_held || w_aw_hs;
        w_w_held_nxt  = r_w_held || w_w_hs;
        if (w_aw_held_nxt && w_w_held_nxt) w_wst_nxt = W_EXEC;
      end
      W_EXEC: begin
        w_aw_held_nxt = 1'b0;
        w_w_held_nxt  = 1'b0;
        w_bresp_nxt   = r_aw_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        w_wst_nxt     = W_RESP;
      end
      W_RESP: begin
        if (r_bvalid && s_axi.bready) w_wst_nxt = W_IDLE;
      end
      default: w_wst_nxt = W_IDLE;
    endcase
    w_awready_nxt = (w_wst_nxt == W_IDLE) && !w_aw_held_nxt;
    w_wready_nxt  = (w_wst_nxt == W_IDLE) && !w_w_held_nxt;
    // bvalid rises one cycle into W_RESP so the response stays fully registered.
    w_bvalid_nxt  = (r_wst == W_RESP) && !(r_bvalid && s_axi.bready);
  end

  always_comb begin
    w_rst_nxt = r_rst;
    case (r_rst)
      R_IDLE:  if (w_ar_hs) w_rst_nxt = R_ACC;
      R_ACC:   if (r_wst != W_EXEC) w_rst_nxt = R_DATA;
      R_DATA:  if (r_rvalid && s_axi.rready) w_rst_nxt = R_IDLE;
      default: w_rst_nxt = R_IDLE;
    endcase
    w_arready_nxt = (w_rst_nxt == R_IDLE);
    w_rvalid_nxt  = (r_rst == R_DATA) && !(r_rvalid && s_axi.rready);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wst     <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_ok   <= 1'b0;
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= AXI_RESP_OKAY;
    end else begin
      r_wst     <= w_wst_nxt;
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      if (w_aw_hs) begin
        r_aw_ok  <= addr_ok(s_axi.awaddr);
        r_aw_idx <= addr_idx(s_axi.awaddr);
      end
      if (w_w_hs) begin
        r_wdata <= s_axi.wdata;
        r_wstrb <= s_axi.wstrb;
      end
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rst     <= R_IDLE;
      r_ar_ok   <= 1'b0;
      r_ar_idx  <= '0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= AXI_RESP_OKAY;
    end else begin
      r_rst     <= w_rst_nxt;
      if (w_ar_hs) begin
        r_ar_ok  <= addr_ok(s_axi.araddr);
        r_ar_idx <= addr_idx(s_axi.araddr);
      end
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      if (r_rst == R_DATA && !r_rvalid) begin
        r_rdata <= r_ar_ok ? w_rd_word : 32'h0;
        r_rresp <= r_ar_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end
    end
  end

  assign w_ram_wr   = (r_wst == W_EXEC) && r_aw_ok;
  assign w_ram_rd   = (r_rst == R_ACC) && (r_wst != W_EXEC) && r_ar_ok;
  assign w_ram_en   = w_ram_wr || w_ram_rd;
  assign w_ram_addr = w_ram_wr ? r_aw_idx : r_ar_idx;

`ifdef AXI_RAM_BIG_ENDIAN_EN
  assign w_ram_wdata = byte_swap32(r_wdata);
  assign w_ram_we    = w_ram_wr ? strb_swap(r_wstrb) : 4'b0000;
  assign w_rd_word   = byte_swap32(w_ram_rdata);
`else
  assign w_ram_wdata = r_wdata;
  assign w_ram_we    = w_ram_wr ? r_wstrb : 4'b0000;
  assign w_rd_word   = w_ram_rdata;
`endif

  ram_sp_be #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .en    (w_ram_en),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (w_ram_wdata),
    .rdata (w_ram_rdata)
  );

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_ram.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_lite_ram
// Brief  : Directed self-checking bench for axi_lite_ram (default build).
// Rev    : 1.0
// ============================================================================
module tb_axi_lite_ram;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_err;

  axi_lite_ram_if bus();

  axi_lite_ram #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0000_0000)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .s_axi (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                           output logic [1:0] resp, output int lat);
    bit aw_done, w_done, hs_aw, hs_w;
    int n;
    aw_done = 0; w_done = 0;
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata  = d; bus.wstrb   = st; bus.wvalid = 1'b1;
    n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      hs_aw = bus.awvalid && bus.awready;
      hs_w  = bus.wvalid && bus.wready;
      tick();
      if (hs_aw) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (hs_w)  begin w_done  = 1; bus.wvalid  = 1'b0; end
      n++;
    end
    lat = 0;
    while (!bus.bvalid && lat < 20) begin tick(); lat++; end
    chk("bvalid_wait", {31'b0, bus.bvalid}, 32'd1);
    resp = bus.bresp;
    tick();
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
    int n;
    bus.araddr = a; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 20) begin tick(); n++; end
    tick();
    bus.arvalid = 1'b0;
    lat = 0;
    while (!bus.rvalid && lat < 20) begin tick(); lat++; end
    chk("rvalid_wait", {31'b0, bus.rvalid}, 32'd1);
    d    = bus.rdata;
    resp = bus.rresp;
    tick();
  endtask

  function automatic logic [31:0] outs();
    return {bus.rdata[31:11], bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid,
            bus.rresp, bus.bresp, bus.rdata[10:9] | bus.rdata[8:7], bus.rdata[6:0] != 7'd0};
  endfunction

  initial begin
    logic [31:0] d;
    logic [1:0]  resp;
    int          lat, bcnt, r_lat, b_lat;
    logic [1:0]  b_seen;

    n_chk = 0; n_err = 0;
    rstn = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b1;
    tick(); tick();
    chk("reset_outputs", outs(), 32'h0);
    chk("reset_rdata", bus.rdata, 32'h0);
    rstn = 1'b1;
    tick();
    chk("ready_after_reset", {29'b0, bus.arready, bus.awready, bus.wready}, 32'h7);

    axi_write(32'h10, 32'h1234_5678, 4'hF, resp, lat);
    chk("wr10_bresp", {30'b0, resp}, 32'h0);
    chk("wr10_latency", lat, 32'd2);
    axi_read(32'h10, d, resp, lat);
    chk("rd10_data", d, 32'h1234_5678);
    chk("rd10_rresp", {30'b0, resp}, 32'h0);
    chk("rd10_latency", lat, 32'd2);

    // W leads AW by three cycles
    bus.wdata = 32'hA5A5_A5A5; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    tick(); tick();
    chk("w_first_wready_low", {31'b0, bus.wready}, 32'd0);
    chk("w_first_awready_high", {31'b0, bus.awready}, 32'd1);
    bus.awaddr = 32'h20; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    bcnt = 0; b_seen = 2'b11;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.bvalid) begin bcnt++; b_seen = bus.bresp; end
    end
    chk("w_first_bvalid_count", bcnt, 32'd1);
    chk("w_first_bresp", {30'b0, b_seen}, 32'h0);
    axi_read(32'h20, d, resp, lat);
    chk("rd20_data", d, 32'hA5A5_A5A5);

    axi_write(32'h30, 32'hFFFF_FFFF, 4'hF, resp, lat);
    axi_write(32'h30, 32'h0000_0000, 4'b0101, resp, lat);
    axi_read(32'h30, d, resp, lat);
    chk("strb_0101_data", d, 32'hFF00_FF00);
    axi_write(32'h30, 32'h1111_1111, 4'b0000, resp, lat);
    chk("strb_0000_bresp", {30'b0, resp}, 32'h0);
    axi_read(32'h30, d, resp, lat);
    chk("strb_0000_data", d, 32'hFF00_FF00);

    axi_write(32'h0, 32'h1122_3344, 4'hF, resp, lat);
    axi_read(32'h4000, d, resp, lat);
    chk("oor_rresp", {30'b0, resp}, 32'h2);
    chk("oor_rdata", d, 32'h0);
    axi_write(32'h4000, 32'hDEAD_BEEF, 4'hF, resp, lat);
    chk("oor_bresp", {30'b0, resp}, 32'h2);
    axi_read(32'h0, d, resp, lat);
    chk("word0_not_aliased", d, 32'h1122_3344);
    axi_read(32'h3FFC, d, resp, lat);
    chk("last_word_rresp", {30'b0, resp}, 32'h0);

    // AR and AW/W all handshake on the same edge; read must stall behind W_EXEC
    bus.awaddr = 32'h40; bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF;
    bus.araddr = 32'h40;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    r_lat = -1; b_lat = -1; d = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.bvalid && b_lat < 0) b_lat = i;
      if (bus.rvalid && r_lat < 0) begin r_lat = i; d = bus.rdata; end
    end
    chk("conflict_b_latency", b_lat, 32'd2);
    chk("conflict_r_latency", r_lat, 32'd3);
    chk("conflict_rdata", d, 32'hCAFE_F00D);

    bus.bready = 1'b0;
    bus.awaddr = 32'h50; bus.awvalid = 1'b1;
    bus.wdata = 32'h5555_AAAA; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("bready_hold", {28'b0, bus.bvalid, bus.bresp, bus.awready | bus.wready}, 32'h8);
      tick();
    end
    bus.bready = 1'b1;
    tick();
    chk("b_release", {29'b0, bus.bvalid, bus.awready, bus.wready}, 32'h3);

    // Reset asserted while a read is in flight
    bus.araddr = 32'h10; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    tick();
    rstn = 1'b0;
    #1;
    chk("midread_reset_outputs", outs(), 32'h0);
    tick();
    chk("midread_reset_next", outs(), 32'h0);
    rstn = 1'b1;
    tick();
    chk("midread_ready_back", {29'b0, bus.arready, bus.awready, bus.wready}, 32'h7);
    axi_read(32'h10, d, resp, lat);
    chk("post_reset_ram_kept", d, 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
